wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone B3 arbiter that shares a single slave port between the processor instruction bus (master 0) and data bus (master 1).
- Sits between the CPU bus masters and the memory/peripheral fabric.
- Arbitration is round-robin. Ownership is held for the whole cycle (cyc asserted), which keeps burst, CTI and lock semantics intact.
- Grant is registered, so arbitration costs one cycle.

Parameters:
- ADDR_WIDTH, 32, width of the adr bus on all ports.
- DATA_WIDTH, 32, width of the data buses; sel width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN); legal range 1..65535.

Ports:
- clock  input  1  bus clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0); same name as the codebase reset net, polarity fixed low.
- mN_cyc, mN_stb, mN_we  input  1 each  master N (N=0,1) cycle, strobe, write enable.
- mN_adr  input  ADDR_WIDTH  master N address.
- mN_dat_w  input  DATA_WIDTH  master N write data.
- mN_sel  input  DATA_WIDTH/8  master N byte select.
- mN_cti  input  3  master N cycle type tag.
- mN_bte  input  2  master N burst type extension.
- mN_ack, mN_err, mN_rty  output  1 each  terminations returned to master N.
- mN_dat_r  output  DATA_WIDTH  read data; driven to both masters from s_dat_r.
- s_cyc, s_stb, s_we  output  1 each  slave-side cycle, strobe, write enable.
- s_adr, s_dat_w, s_sel, s_cti, s_bte  output  widths as master side  muxed from the owner.
- s_ack, s_err, s_rty  input  1 each  slave terminations.
- s_dat_r  input  DATA_WIDTH  slave read data.
- grant  output  2  one-hot owner (bit0 = m0, bit1 = m1), 2'b00 when idle.

Behaviour:
- FSM states: IDLE, OWN0, OWN1 (plus ABORT when the optional feature is compiled in). Reset state is IDLE.
- Register last_grant resets to 1, so m0 wins the first tie.
- Reset values: all outputs 0; grant = 00.
- IDLE:
  - m0_cyc only -> OWN0 next edge.
  - m1_cyc only -> OWN1 next edge.
  - Both -> the master other than last_grant.
  - Neither -> stay IDLE.
- Entering OWNn sets last_grant = n.
- OWNn, while mn_cyc = 1:
  - s_cyc = mn_cyc, s_stb = mn_stb.
  - All other slave-side outputs are combinationally muxed from master n.
  - mn_ack/err/rty = s_ack/err/rty (zero-latency passthrough).
  - The other master sees ack/err/rty = 0.
- OWNn, when mn_cyc = 0:
  - The release cycle itself drives s_cyc = 0.
  - Next state is chosen that same edge: if the other master's cyc = 1, go directly to its OWN state; else if mn_cyc has been reasserted, go to IDLE and re-arbitrate next cycle; else IDLE.
  - No master is ever granted two consecutive cycles unless the other is idle.
- Latency:
  - Request in IDLE -> s_cyc high 1 cycle later.
  - Handover between masters -> 1 dead cycle (release cycle).
- s_cyc, s_stb, s_we, s_adr and other slave-side outputs are 0 in IDLE. No glitch-free requirement beyond synchronous correctness.
- A master whose cyc is low never receives a termination.
- If s_ack, s_err and s_rty assert together, they are all passed through unchanged; priority is the master's concern.
- Reset assertion mid-cycle:
  - Immediately (asynchronously) drops s_cyc, s_stb and all terminations.
  - Returns to IDLE with last_grant = 1.
- A master dropping cyc mid-burst is legal; ownership is released as above.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter increments each cycle s_cyc & s_stb = 1 with no s_ack/s_err/s_rty.
  - The counter clears on any termination, on state change, or when stb = 0.
  - When the counter reaches TIMEOUT_CYCLES, the owner receives a one-cycle err pulse and the FSM enters ABORT.
  - ABORT forces s_cyc = s_stb = 0 and suppresses all terminations. It holds until the owner drops cyc, then follows the normal release rules.
- Without the macro: no counter, no ABORT state; the arbiter never generates err itself.

Test Plan:
- Reset held low 3 cycles, then released; no requests -> grant = 00, s_cyc = 0, all mN_ack = 0.
- m0 single read, adr 0x100; slave acks on its 2nd stb cycle with s_dat_r 0xDEADBEEF -> s_cyc rises 1 cycle after m0_cyc; m0_ack for 1 cycle with m0_dat_r 0xDEADBEEF; m1_ack stays 0.
- m0 and m1 raise cyc on the same edge from reset -> grant = 01 first; after m0 drops cyc, 1 dead cycle, then grant = 10 and s_adr = m1_adr.
- m1 holds a 4-beat incrementing burst (cti 010, last 111) while m0 requests -> all 4 acks go to m1; m0 is granted only after m1_cyc falls.
- reset driven low mid-transfer while grant = 10 -> s_cyc = 0 and grant = 00 without waiting for a clock edge; first tie after release goes to m0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never responds -> m0_err pulses exactly once 8 cycles after stb; s_cyc = 0 until m0 drops cyc; without the macro, s_cyc stays high indefinitely.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master / one-slave Wishbone B3 round-robin arbiter.
// Optional watchdog abort: define WB_ARB_TIMEOUT_EN.
//
// Ports:
//   clock, reset        bus clock, async active-low reset
//   mN_cyc/stb/we/adr/dat_w/sel/cti/bte  master N request (N=0,1)
//   mN_ack/err/rty/dat_r                 master N response
//   s_cyc/stb/we/adr/dat_w/sel/cti/bte   slave request (muxed from owner)
//   s_ack/err/rty/dat_r                  slave response
//   grant               one-hot owner, 00 when idle
module wb_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [DATA_WIDTH-1:0]   m0_dat_w,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,
  output logic [DATA_WIDTH-1:0]   m0_dat_r,

  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [DATA_WIDTH-1:0]   m1_dat_w,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,
  output logic [DATA_WIDTH-1:0]   m1_dat_r,

  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_adr,
  output logic [DATA_WIDTH-1:0]   s_dat_w,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  input  logic [DATA_WIDTH-1:0]   s_dat_r,

  output logic [1:0]              grant
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("wb_bus_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
    ,
    ABORT = 2'd3
`endif
  } state_e;

  state_e state_q, state_d;
  // 0 = m0 owned last, 1 = m1 owned last
  logic   last_q, last_d;

  logic sel0, sel1;
  logic term;
  logic tmo_hit;

  // owner is active only while it keeps cyc high
  assign sel0 = (state_q == OWN0) & m0_cyc;
  assign sel1 = (state_q == OWN1) & m1_cyc;
  assign term = s_ack | s_err | s_rty;

  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;
  logic        stb_act;

  assign stb_act = (sel0 & m0_stb) | (sel1 & m1_stb);
  assign tmo_hit = stb_act & ~term & (cnt_q == TMO);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (state_d != state_q || !stb_act || term)
      cnt_d = '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          m0_cyc & m1_cyc: state_d = last_q ? OWN0 : OWN1;
          m0_cyc & ~m1_cyc: state_d = OWN0;
          ~m0_cyc & m1_cyc: state_d = OWN1;
          default: state_d = IDLE;
        endcase
      end
      OWN0: begin
        if (!m0_cyc)
          state_d = m1_cyc ? OWN1 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        else if (tmo_hit)
          state_d = ABORT;
`endif
      end
      OWN1: begin
        if (!m1_cyc)
          state_d = m0_cyc ? OWN0 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        else if (tmo_hit)
          state_d = ABORT;
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      // last_q still names the aborted owner
      ABORT: begin
        if (last_q ? !m1_cyc : !m0_cyc) begin
          if (last_q)
            state_d = m0_cyc ? OWN0 : IDLE;
          else
            state_d = m1_cyc ? OWN1 : IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == OWN0 && state_q != OWN0)
      last_d = 1'b0;
    else if (state_d == OWN1 && state_q != OWN1)
      last_d = 1'b1;
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_cti   = '0;
    s_bte   = '0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m0_rty  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    m1_rty  = 1'b0;
    grant   = 2'b00;

    unique case (state_q)
      OWN0: grant = 2'b01;
      OWN1: grant = 2'b10;
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: grant = last_q ? 2'b10 : 2'b01;
`endif
      default: grant = 2'b00;
    endcase

    if (sel0) begin
      s_cyc   = 1'b1;
      s_stb   = m0_stb;
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_dat_w = m0_dat_w;
      s_sel   = m0_sel;
      s_cti   = m0_cti;
      s_bte   = m0_bte;
      m0_ack  = s_ack;
      m0_err  = s_err | tmo_hit;
      m0_rty  = s_rty;
    end else if (sel1) begin
      s_cyc   = 1'b1;
      s_stb   = m1_stb;
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_dat_w = m1_dat_w;
      s_sel   = m1_sel;
      s_cti   = m1_cti;
      s_bte   = m1_bte;
      m1_ack  = s_ack;
      m1_err  = s_err | tmo_hit;
      m1_rty  = s_rty;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed bench for wb_bus_arbiter.
// Expected values queued at drive time, popped at sample time.
module tb_wb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;

  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_w;
  logic [SW-1:0] m0_sel;
  logic [2:0]    m0_cti;
  logic [1:0]    m0_bte;
  logic          m0_ack, m0_err, m0_rty;
  logic [DW-1:0] m0_dat_r;

  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_w;
  logic [SW-1:0] m1_sel;
  logic [2:0]    m1_cti;
  logic [1:0]    m1_bte;
  logic          m1_ack, m1_err, m1_rty;
  logic [DW-1:0] m1_dat_r;

  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w;
  logic [SW-1:0] s_sel;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic          s_ack, s_err, s_rty;
  logic [DW-1:0] s_dat_r;
  logic [1:0]    grant;

  always #5 clock = ~clock;

  wb_bus_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .m0_cyc  (m0_cyc),
    .m0_stb  (m0_stb),
    .m0_we   (m0_we),
    .m0_adr  (m0_adr),
    .m0_dat_w(m0_dat_w),
    .m0_sel  (m0_sel),
    .m0_cti  (m0_cti),
    .m0_bte  (m0_bte),
    .m0_ack  (m0_ack),
    .m0_err  (m0_err),
    .m0_rty  (m0_rty),
    .m0_dat_r(m0_dat_r),
    .m1_cyc  (m1_cyc),
    .m1_stb  (m1_stb),
    .m1_we   (m1_we),
    .m1_adr  (m1_adr),
    .m1_dat_w(m1_dat_w),
    .m1_sel  (m1_sel),
    .m1_cti  (m1_cti),
    .m1_bte  (m1_bte),
    .m1_ack  (m1_ack),
    .m1_err  (m1_err),
    .m1_rty  (m1_rty),
    .m1_dat_r(m1_dat_r),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_adr   (s_adr),
    .s_dat_w (s_dat_w),
    .s_sel   (s_sel),
    .s_cti   (s_cti),
    .s_bte   (s_bte),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .s_rty   (s_rty),
    .s_dat_r (s_dat_r),
    .grant   (grant)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;

  task automatic expect_v(input string tag, input logic [63:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [63:0] obs);
    sb_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h expected <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0;
    m0_dat_w = '0; m0_sel = '0; m0_cti = '0; m0_bte = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0;
    m1_dat_w = '0; m1_sel = '0; m1_cti = '0; m1_bte = '0;
    s_ack = 0; s_err = 0; s_rty = 0; s_dat_r = '0;
    reset = 0;

    // reset held three cycles
    repeat (3) @(posedge clock);
    #1;
    expect_v("rst_grant", 0); check(64'(grant));
    expect_v("rst_scyc", 0);  check(64'(s_cyc));
    #1 reset = 1;
    step(); settle();
    expect_v("idle_grant", 0); check(64'(grant));
    expect_v("idle_scyc", 0);  check(64'(s_cyc));
    expect_v("idle_m0ack", 0); check(64'(m0_ack));
    expect_v("idle_m1ack", 0); check(64'(m1_ack));

    // m0 single read, ack on second stb cycle
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m0_sel = 4'hf;
    expect_v("rd_req_scyc", 0);
    settle(); check(64'(s_cyc));
    expect_v("rd_scyc", 1);
    expect_v("rd_grant", 1);
    expect_v("rd_sadr", 32'h100);
    expect_v("rd_wait_ack", 0);
    step(); settle();
    check(64'(s_cyc)); check(64'(grant));
    check(64'(s_adr)); check(64'(m0_ack));
    step();
    s_ack = 1; s_dat_r = 32'hDEADBEEF;
    expect_v("rd_ack", 1);
    expect_v("rd_dat", 32'hDEADBEEF);
    expect_v("rd_m1ack", 0);
    settle();
    check(64'(m0_ack)); check(64'(m0_dat_r)); check(64'(m1_ack));
    step();
    s_ack = 0; s_dat_r = '0; m0_cyc = 0; m0_stb = 0;
    expect_v("rd_rel_scyc", 0);
    expect_v("rd_rel_ack", 0);
    settle(); check(64'(s_cyc)); check(64'(m0_ack));
    expect_v("rd_idle_grant", 0);
    step(); settle(); check(64'(grant));

    // fresh reset so the tie starts from last_grant = 1
    reset = 0;
    step();
    reset = 1;

    // simultaneous requests
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h200;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
    expect_v("tie_grant", 1);
    expect_v("tie_sadr", 32'h200);
    step(); settle();
    check(64'(grant)); check(64'(s_adr));
    s_ack = 1;
    expect_v("tie_m0ack", 1);
    expect_v("tie_m1ack", 0);
    settle(); check(64'(m0_ack)); check(64'(m1_ack));
    step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    expect_v("ho_dead_scyc", 0);
    settle(); check(64'(s_cyc));
    expect_v("ho_grant", 2);
    expect_v("ho_sadr", 32'h300);
    expect_v("ho_scyc", 1);
    step(); settle();
    check(64'(grant)); check(64'(s_adr)); check(64'(s_cyc));

    // m1 4-beat incrementing burst while m0 waits
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) step();
      m1_cti = (b == 3) ? 3'b111 : 3'b010;
      m1_adr = 32'h300 + 32'(4 * b);
      s_ack  = 1;
      expect_v("bu_m1ack", 1);
      expect_v("bu_m0ack", 0);
      expect_v("bu_grant", 2);
      expect_v("bu_scti", 64'(m1_cti));
      expect_v("bu_sadr", 64'(m1_adr));
      settle();
      check(64'(m1_ack)); check(64'(m0_ack));
      check(64'(grant));  check(64'(s_cti));
      check(64'(s_adr));
    end
    step();
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_cti = 0;
    expect_v("bu_rel_scyc", 0);
    expect_v("bu_rel_grant", 2);
    settle(); check(64'(s_cyc)); check(64'(grant));
    expect_v("bu_m0_grant", 1);
    expect_v("bu_m0_sadr", 32'h400);
    step(); settle(); check(64'(grant)); check(64'(s_adr));
    step();
    m0_cyc = 0; m0_stb = 0;
    expect_v("bu_idle", 0);
    step(); settle(); check(64'(grant));

    // async reset while m1 owns the bus
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h500;
    expect_v("ar_pre_grant", 2);
    expect_v("ar_pre_scyc", 1);
    step(); settle(); check(64'(grant)); check(64'(s_cyc));
    reset = 0;
    s_ack = 1;
    expect_v("ar_scyc", 0);
    expect_v("ar_sstb", 0);
    expect_v("ar_grant", 0);
    expect_v("ar_m1ack", 0);
    #1;
    check(64'(s_cyc)); check(64'(s_stb));
    check(64'(grant)); check(64'(m1_ack));
    s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h600;
    step();
    reset = 1;
    expect_v("ar_idle", 0);
    settle(); check(64'(grant));
    expect_v("ar_tie", 1);
    step(); settle(); check(64'(grant));
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step();
    expect_v("ar_end_idle", 0);
    step(); settle(); check(64'(grant));

    // silent slave
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h700;
    step(); settle();
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        step(); settle();
      end
      expect_v($sformatf("to_err_c%0d", c), (c == 8) ? 1 : 0);
      expect_v($sformatf("to_scyc_c%0d", c), (c <= 8) ? 1 : 0);
      check(64'(m0_err)); check(64'(s_cyc));
    end
    m0_cyc = 0; m0_stb = 0;
    expect_v("to_rel_scyc", 0);
    settle(); check(64'(s_cyc));
    expect_v("to_idle", 0);
    step(); settle(); check(64'(grant));
`else
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin
        step(); settle();
      end
      expect_v($sformatf("nt_scyc_c%0d", c), 1);
      expect_v($sformatf("nt_err_c%0d", c), 0);
      check(64'(s_cyc)); check(64'(m0_err));
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    expect_v("nt_idle", 0);
    step(); settle(); check(64'(grant));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
